// File: rtl/lcd_pkg.sv
// Shared ILI9341 definitions: opcodes, scheduler states, bus byte payload and window preamble table.
package lcd_pkg;

  localparam logic [7:0] OP_CASET = 8'h2A;
  localparam logic [7:0] OP_PASET = 8'h2B;
  localparam logic [7:0] OP_RAMWR = 8'h2C;

  localparam int unsigned DEFAULT_COL_END  = 239;
  localparam int unsigned DEFAULT_PAGE_END = 319;
  localparam int unsigned WIN_BYTES        = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARM,
    ST_WIN,
    ST_PIXEL
  } state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } bus_byte_t;

  // Window preamble: CASET 0..col_end, PASET 0..page_end, RAMWR
  function automatic bus_byte_t win_byte(input logic [3:0]  idx,
                                         input logic [15:0] col_end,
                                         input logic [15:0] page_end);
    bus_byte_t b;
    b.rs   = 1'b1;
    b.data = 8'h00;
    case (idx)
      4'd0:    begin b.rs = 1'b0; b.data = OP_CASET; end
      4'd3:    b.data = col_end[15:8];
      4'd4:    b.data = col_end[7:0];
      4'd5:    begin b.rs = 1'b0; b.data = OP_PASET; end
      4'd8:    b.data = page_end[15:8];
      4'd9:    b.data = page_end[7:0];
      4'd10:   begin b.rs = 1'b0; b.data = OP_RAMWR; end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_fmark_sync.sv
// Synchronizes the panel tearing-effect mark and produces a one-cycle rising-edge pulse.
module lcd_fmark_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_fmark,
  output logic o_rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_fmark};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign o_rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Frame scheduler for an 8080 LCD byte writer: TE-synced window preamble plus RGB565 pixel
// stream, with host command pass-through between frames.
module lcd_frame_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned COL_END    = DEFAULT_COL_END,
  parameter int unsigned PAGE_END   = DEFAULT_PAGE_END,
  parameter int unsigned FMARK_SYNC = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_lcd_fmark,
  input  logic        i_cmd_valid,
  input  logic        i_cmd_rs,
  input  logic [7:0]  i_cmd_data,
  output logic        o_cmd_ready,
  input  logic        i_px_valid,
  input  logic [15:0] i_px_data,
  output logic        o_px_ready,
  output logic        o_bus_valid,
  output logic        o_bus_rs,
  output logic [7:0]  o_bus_data,
  input  logic        i_bus_ready,
  output logic        o_frame_start,
  output logic        o_frame_done,
  output logic        o_tear_miss
);

  localparam int unsigned NPIX = (COL_END + 1) * (PAGE_END + 1);
  localparam int unsigned PXW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PXW-1:0] PX_LAST  = PXW'(NPIX - 1);
  localparam logic [15:0]    COL_W    = 16'(COL_END);
  localparam logic [15:0]    PAGE_W   = 16'(PAGE_END);
  localparam logic [3:0]     WIN_LAST = 4'(WIN_BYTES - 1);

  state_t          state, state_n;
  logic [3:0]      win_idx, win_idx_n;
  logic [PXW-1:0]  px_cnt, px_cnt_n;
  logic            px_all, px_all_n;
  logic            lo_pend, lo_pend_n;
  logic [7:0]      px_lo, px_lo_n;
  logic            first_px, first_px_n;
  bus_byte_t       bus_q, bus_n;
  logic            bus_valid_n;
  logic            frame_start_n, frame_done_n, tear_miss_n;
  logic            cmd_ready_c, px_ready_c;
  logic            fm_rise, xfer, bus_free;

  lcd_fmark_sync #(.STAGES(FMARK_SYNC)) u_fmark_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_fmark (i_lcd_fmark),
    .o_rise  (fm_rise)
  );

  assign xfer     = o_bus_valid & i_bus_ready;
  assign bus_free = ~o_bus_valid | i_bus_ready;

  // Next-state and next-output logic; bus payload only changes when the slot is free
  always_comb begin
    state_n       = state;
    win_idx_n     = win_idx;
    px_cnt_n      = px_cnt;
    px_all_n      = px_all;
    lo_pend_n     = lo_pend;
    px_lo_n       = px_lo;
    first_px_n    = first_px;
    bus_n         = bus_q;
    bus_valid_n   = o_bus_valid;
    frame_start_n = 1'b0;
    frame_done_n  = 1'b0;
    tear_miss_n   = o_tear_miss | (fm_rise & ((state == ST_WIN) | (state == ST_PIXEL)));
    cmd_ready_c   = 1'b0;
    px_ready_c    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          state_n     = ST_CMD;
          bus_valid_n = 1'b1;
          bus_n.rs    = i_cmd_rs;
          bus_n.data  = i_cmd_data;
        end else if (i_enable) begin
          state_n = ST_ARM;
        end
      end
      ST_CMD: begin
        cmd_ready_c = xfer;
        if (xfer) begin
          state_n     = ST_IDLE;
          bus_valid_n = 1'b0;
        end
      end
      ST_ARM: begin
        if (!i_enable) begin
          state_n = ST_IDLE;
        end else if (fm_rise) begin
          state_n     = ST_WIN;
          win_idx_n   = 4'd0;
          bus_valid_n = 1'b1;
          bus_n       = win_byte(4'd0, COL_W, PAGE_W);
        end
      end
      ST_WIN: begin
        if (xfer) begin
          if (win_idx == WIN_LAST) begin
            state_n     = ST_PIXEL;
            bus_valid_n = 1'b0;
            px_cnt_n    = '0;
            px_all_n    = 1'b0;
            lo_pend_n   = 1'b0;
            first_px_n  = 1'b1;
          end else begin
            win_idx_n = win_idx + 4'd1;
            bus_n     = win_byte(win_idx + 4'd1, COL_W, PAGE_W);
          end
        end
      end
      ST_PIXEL: begin
        if (xfer && first_px) begin
          frame_start_n = 1'b1;
          first_px_n    = 1'b0;
        end
        if (xfer && px_all && !lo_pend) begin
          state_n      = ST_IDLE;
          bus_valid_n  = 1'b0;
          frame_done_n = 1'b1;
        end else if (bus_free) begin
          // Low byte of the latched pixel goes first; otherwise fetch the next pixel
          if (lo_pend) begin
            bus_valid_n = 1'b1;
            bus_n.rs    = 1'b1;
            bus_n.data  = px_lo;
            lo_pend_n   = 1'b0;
          end else if (!px_all && i_px_valid) begin
            px_ready_c  = 1'b1;
            bus_valid_n = 1'b1;
            bus_n.rs    = 1'b1;
            bus_n.data  = i_px_data[15:8];
            px_lo_n     = i_px_data[7:0];
            lo_pend_n   = 1'b1;
            if (px_cnt == PX_LAST) begin
              px_all_n = 1'b1;
            end else begin
              px_cnt_n = px_cnt + PXW'(1);
            end
          end else begin
            bus_valid_n = 1'b0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      win_idx       <= 4'd0;
      px_cnt        <= '0;
      px_all        <= 1'b0;
      lo_pend       <= 1'b0;
      px_lo         <= 8'h00;
      first_px      <= 1'b0;
      bus_q         <= '{rs: 1'b1, data: 8'h00};
      o_bus_valid   <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_tear_miss   <= 1'b0;
    end else begin
      state         <= state_n;
      win_idx       <= win_idx_n;
      px_cnt        <= px_cnt_n;
      px_all        <= px_all_n;
      lo_pend       <= lo_pend_n;
      px_lo         <= px_lo_n;
      first_px      <= first_px_n;
      bus_q         <= bus_n;
      o_bus_valid   <= bus_valid_n;
      o_frame_start <= frame_start_n;
      o_frame_done  <= frame_done_n;
      o_tear_miss   <= tear_miss_n;
    end
  end

  assign o_bus_rs    = bus_q.rs;
  assign o_bus_data  = bus_q.data;
  assign o_cmd_ready = cmd_ready_c & ~i_reset;
  assign o_px_ready  = px_ready_c & ~i_reset;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Scoreboard bench for lcd_frame_scheduler on a reduced 4x258 panel geometry.
module tb_lcd_frame_scheduler;

  localparam int unsigned COL_END     = 3;
  localparam int unsigned PAGE_END    = 257;
  localparam int unsigned NPIX        = (COL_END + 1) * (PAGE_END + 1);
  localparam int unsigned FRAME_BYTES = 11 + 2 * NPIX;

  logic        i_clk, i_reset, i_enable, i_lcd_fmark;
  logic        i_cmd_valid, i_cmd_rs;
  logic [7:0]  i_cmd_data;
  logic        o_cmd_ready;
  logic        i_px_valid;
  logic [15:0] i_px_data;
  logic        o_px_ready, o_bus_valid, o_bus_rs;
  logic [7:0]  o_bus_data;
  logic        i_bus_ready;
  logic        o_frame_start, o_frame_done, o_tear_miss;

  lcd_frame_scheduler #(.COL_END(COL_END), .PAGE_END(PAGE_END), .FMARK_SYNC(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_lcd_fmark(i_lcd_fmark),
    .i_cmd_valid(i_cmd_valid), .i_cmd_rs(i_cmd_rs), .i_cmd_data(i_cmd_data),
    .o_cmd_ready(o_cmd_ready), .i_px_valid(i_px_valid), .i_px_data(i_px_data),
    .o_px_ready(o_px_ready), .o_bus_valid(o_bus_valid), .o_bus_rs(o_bus_rs),
    .o_bus_data(o_bus_data), .i_bus_ready(i_bus_ready), .o_frame_start(o_frame_start),
    .o_frame_done(o_frame_done), .o_tear_miss(o_tear_miss)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_tests, n_fail;
  logic [8:0]  exp_q[$];
  logic [8:0]  cmd_q[$];
  logic [15:0] px_src[$];
  bit          px_gate, consume_pending, stall_hold;
  int          ready_mode;
  int          byte_cnt, px_ready_cnt, fs_cnt, fd_cnt, cmd_cnt;
  logic [8:0]  held;

  // Pixel source and bus-ready pattern, updated just after each active edge
  always @(posedge i_clk) begin
    #2;
    if (consume_pending) begin
      if (px_src.size() > 0) px_src.delete(0);
      consume_pending = 1'b0;
    end
    i_px_valid = px_gate && (px_src.size() > 0);
    i_px_data  = (px_src.size() > 0) ? px_src[0] : 16'h0000;
    case (ready_mode)
      0:       i_bus_ready = 1'b1;
      1:       i_bus_ready = ~i_bus_ready;
      default: i_bus_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: bytes popped against the scoreboard, hold-while-stalled, pulse counters
  always @(negedge i_clk) begin
    logic [8:0] got, exp;
    if (i_reset) begin
      stall_hold = 1'b0;
    end else begin
      got = {o_bus_rs, o_bus_data};
      if (stall_hold) begin
        n_tests++;
        if (o_bus_valid !== 1'b1 || got !== held) begin
          n_fail++;
          $display("FAIL bus_hold: valid=%b byte=%h, required valid=1 byte=%h", o_bus_valid, got, held);
        end
      end
      if (o_px_ready && i_px_valid) begin
        px_ready_cnt++;
        consume_pending = 1'b1;
        exp_q.push_back({1'b1, px_src[0][15:8]});
        exp_q.push_back({1'b1, px_src[0][7:0]});
      end
      if (o_bus_valid && i_bus_ready) begin
        byte_cnt++;
        n_tests++;
        if (o_cmd_ready) begin
          cmd_cnt++;
          if (cmd_q.size() == 0) begin
            n_fail++;
            $display("FAIL cmd_byte: unexpected host byte %h", got);
          end else begin
            exp = cmd_q.pop_front();
            if (got !== exp) begin
              n_fail++;
              $display("FAIL cmd_byte: got %h, required %h", got, exp);
            end
          end
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bus_byte: unexpected byte %h", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL bus_byte: got {rs,data}=%h, required %h", got, exp);
          end
        end
      end else if (o_cmd_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL cmd_ready: asserted without a bus transfer");
      end
      stall_hold = o_bus_valid && !i_bus_ready;
      held = got;
      if (o_frame_start) fs_cnt++;
      if (o_frame_done) fd_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic pulse_fmark();
    i_lcd_fmark = 1'b1;
    tick(3);
    i_lcd_fmark = 1'b0;
  endtask

  task automatic push_preamble();
    logic [15:0] c, p;
    c = 16'(COL_END);
    p = 16'(PAGE_END);
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, c[15:8]});
    exp_q.push_back({1'b1, c[7:0]});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, p[15:8]});
    exp_q.push_back({1'b1, p[7:0]});
    exp_q.push_back({1'b0, 8'h2C});
  endtask

  task automatic load_pixels(input logic [15:0] first);
    px_src.push_back(first);
    for (int i = 1; i < int'(NPIX); i++) px_src.push_back(16'($urandom));
  endtask

  task automatic wait_start(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fs_cnt >= target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * int'(FRAME_BYTES); i++) begin
      if (fd_cnt >= target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b0; i_lcd_fmark = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_rs = 1'b0; i_cmd_data = 8'h00;
    px_gate = 1'b1; ready_mode = 0; i_bus_ready = 1'b1;
    px_src.push_back(16'h1234);
    tick(3);
    n_tests += 3;
    if ({o_bus_valid, o_bus_rs, o_bus_data} !== 10'b0_1_00000000) begin
      n_fail++;
      $display("FAIL reset_bus: valid/rs/data=%b/%b/%h, required 0/1/00", o_bus_valid, o_bus_rs, o_bus_data);
    end
    if ({o_cmd_ready, o_px_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: cmd/px=%b%b, required 00", o_cmd_ready, o_px_ready);
    end
    if ({o_frame_start, o_frame_done, o_tear_miss} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: start/done/tear=%b%b%b, required 000", o_frame_start, o_frame_done, o_tear_miss);
    end
    i_reset = 1'b0;
    px_src.delete();
    tick(2);
  endtask

  task automatic test_full_frame();
    int b0, p0, s0, d0;
    bit ok;
    b0 = byte_cnt; p0 = px_ready_cnt; s0 = fs_cnt; d0 = fd_cnt;
    ready_mode = 0;
    load_pixels(16'($urandom));
    push_preamble();
    i_enable = 1'b1;
    tick(2);
    pulse_fmark();
    wait_done(d0 + 1, ok);
    i_enable = 1'b0;
    tick(20);
    n_tests += 5;
    if (!ok) begin n_fail++; $display("FAIL full_done: no frame_done within budget"); end
    if (byte_cnt - b0 != int'(FRAME_BYTES)) begin
      n_fail++;
      $display("FAIL full_bytes: %0d bytes, required %0d", byte_cnt - b0, FRAME_BYTES);
    end
    if (px_ready_cnt - p0 != int'(NPIX)) begin
      n_fail++;
      $display("FAIL full_pixels: %0d px_ready pulses, required %0d", px_ready_cnt - p0, NPIX);
    end
    if (fs_cnt - s0 != 1 || fd_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL full_pulses: start=%0d done=%0d, required 1/1", fs_cnt - s0, fd_cnt - d0);
    end
    if (exp_q.size() != 0 || o_tear_miss !== 1'b0) begin
      n_fail++;
      $display("FAIL full_tail: %0d bytes outstanding, tear=%b, required 0/0", exp_q.size(), o_tear_miss);
    end
  endtask

  task automatic test_backpressure();
    int p0, d0, b1;
    bit ok_s, ok_d;
    p0 = px_ready_cnt; d0 = fd_cnt;
    ready_mode = 1;
    load_pixels(16'hF800);
    push_preamble();
    i_enable = 1'b1;
    tick(2);
    pulse_fmark();
    wait_start(fs_cnt + 1, ok_s);
    i_enable = 1'b0;
    wait_done(d0 + 1, ok_d);
    tick(5);
    b1 = byte_cnt;
    pulse_fmark();
    tick(30);
    n_tests += 4;
    if (!ok_s || !ok_d) begin
      n_fail++;
      $display("FAIL bp_frame: start_seen=%b done_seen=%b, required 1/1", ok_s, ok_d);
    end
    if (px_ready_cnt - p0 != int'(NPIX)) begin
      n_fail++;
      $display("FAIL bp_pixels: %0d px_ready pulses, required %0d", px_ready_cnt - p0, NPIX);
    end
    if (byte_cnt != b1) begin
      n_fail++;
      $display("FAIL bp_disabled: %0d bytes after enable low, required 0", byte_cnt - b1);
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_tail: %0d bytes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_cmd();
    int c0, b0, d0;
    bit ok, ok_s, granted;
    ready_mode = 2;
    c0 = cmd_cnt; b0 = byte_cnt;
    cmd_q.push_back({1'b0, 8'h36});
    i_cmd_valid = 1'b1; i_cmd_rs = 1'b0; i_cmd_data = 8'h36;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cmd_cnt > c0) begin ok = 1'b1; break; end
    end
    i_cmd_valid = 1'b0;
    tick(10);
    n_tests += 2;
    if (!ok || cmd_cnt - c0 != 1) begin
      n_fail++;
      $display("FAIL cmd_idle: %0d grants, required 1", cmd_cnt - c0);
    end
    if (byte_cnt - b0 != 1 || cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL cmd_idle_bytes: %0d bytes, required 1", byte_cnt - b0);
    end
    // Host request raised mid-frame must wait for frame_done
    ready_mode = 0;
    d0 = fd_cnt; c0 = cmd_cnt;
    load_pixels(16'($urandom));
    push_preamble();
    i_enable = 1'b1;
    tick(2);
    pulse_fmark();
    wait_start(fs_cnt + 1, ok_s);
    i_enable = 1'b0;
    cmd_q.push_back({1'b1, 8'h55});
    i_cmd_valid = 1'b1; i_cmd_rs = 1'b1; i_cmd_data = 8'h55;
    granted = 1'b0;
    for (int i = 0; i < 4 * int'(FRAME_BYTES); i++) begin
      tick();
      if (cmd_cnt > c0) begin granted = 1'b1; break; end
    end
    n_tests += 2;
    if (!ok_s || !granted) begin
      n_fail++;
      $display("FAIL cmd_frame_grant: start_seen=%b granted=%b, required 1/1", ok_s, granted);
    end
    if (fd_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL cmd_frame_order: %0d frame_done before grant, required 1", fd_cnt - d0);
    end
    i_cmd_valid = 1'b0;
    tick(10);
  endtask

  task automatic test_tear_miss();
    int d0, b1;
    bit ok_s, ok_d, ok_d2;
    ready_mode = 0;
    d0 = fd_cnt;
    load_pixels(16'($urandom));
    push_preamble();
    i_enable = 1'b1;
    tick(2);
    pulse_fmark();
    wait_start(fs_cnt + 1, ok_s);
    tick(40);
    pulse_fmark();
    tick(10);
    n_tests++;
    if (o_tear_miss !== 1'b1) begin
      n_fail++;
      $display("FAIL tear_set: tear_miss=%b, required 1", o_tear_miss);
    end
    wait_done(d0 + 1, ok_d);
    b1 = byte_cnt;
    tick(60);
    n_tests += 2;
    if (!ok_s || !ok_d || byte_cnt != b1) begin
      n_fail++;
      $display("FAIL tear_no_restart: done_seen=%b extra_bytes=%0d, required 1/0", ok_d, byte_cnt - b1);
    end
    if (o_tear_miss !== 1'b1) begin
      n_fail++;
      $display("FAIL tear_sticky: tear_miss=%b, required 1", o_tear_miss);
    end
    load_pixels(16'($urandom));
    push_preamble();
    pulse_fmark();
    wait_done(d0 + 2, ok_d2);
    i_enable = 1'b0;
    tick(10);
    n_tests++;
    if (!ok_d2 || exp_q.size() != 0 || o_tear_miss !== 1'b1) begin
      n_fail++;
      $display("FAIL tear_next_frame: done=%b outstanding=%0d tear=%b, required 1/0/1", ok_d2, exp_q.size(), o_tear_miss);
    end
  endtask

  task automatic test_stall();
    int p0, b0, d0;
    bit ok_s, ok_d;
    ready_mode = 0;
    p0 = px_ready_cnt; b0 = byte_cnt; d0 = fd_cnt;
    load_pixels(16'($urandom));
    push_preamble();
    i_enable = 1'b1;
    tick(2);
    pulse_fmark();
    wait_start(fs_cnt + 1, ok_s);
    i_enable = 1'b0;
    tick(100);
    px_gate = 1'b0;
    tick(3);
    for (int i = 0; i < 50; i++) begin
      n_tests++;
      if (o_bus_valid !== 1'b0 || o_px_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_idle: cycle %0d valid=%b px_ready=%b, required 0/0", i, o_bus_valid, o_px_ready);
      end
      tick();
    end
    px_gate = 1'b1;
    wait_done(d0 + 1, ok_d);
    tick(10);
    n_tests += 2;
    if (!ok_s || !ok_d || px_ready_cnt - p0 != int'(NPIX)) begin
      n_fail++;
      $display("FAIL stall_pixels: %0d pixels, required %0d", px_ready_cnt - p0, NPIX);
    end
    if (byte_cnt - b0 != int'(FRAME_BYTES) || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_bytes: %0d bytes, required %0d", byte_cnt - b0, FRAME_BYTES);
    end
  endtask

  task automatic test_reset_mid_win();
    int b0, d0;
    bit ok, ok_d;
    ready_mode = 0;
    load_pixels(16'($urandom));
    push_preamble();
    i_enable = 1'b1;
    tick(2);
    b0 = byte_cnt;
    pulse_fmark();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (byte_cnt - b0 >= 5) begin ok = 1'b1; break; end
      tick();
    end
    i_reset = 1'b1;
    tick();
    n_tests += 2;
    if (!ok || o_bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_win_valid: reached=%b valid=%b, required 1/0", ok, o_bus_valid);
    end
    if (o_tear_miss !== 1'b0 || o_bus_rs !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_win_regs: tear=%b rs=%b, required 0/1", o_tear_miss, o_bus_rs);
    end
    i_reset = 1'b0;
    exp_q.delete();
    px_src.delete();
    consume_pending = 1'b0;
    tick(3);
    d0 = fd_cnt;
    load_pixels(16'($urandom));
    push_preamble();
    pulse_fmark();
    wait_done(d0 + 1, ok_d);
    i_enable = 1'b0;
    tick(10);
    n_tests++;
    if (!ok_d || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_win_restart: done=%b outstanding=%0d, required 1/0", ok_d, exp_q.size());
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    byte_cnt = 0; px_ready_cnt = 0; fs_cnt = 0; fd_cnt = 0; cmd_cnt = 0;
    consume_pending = 1'b0; stall_hold = 1'b0; held = '0;
    i_px_valid = 1'b0; i_px_data = 16'h0000;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_cmd();
    test_tear_miss();
    test_stall();
    test_reset_mid_win();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
